aes_inv_cipher: RTL

Iterative AES-128 decryption core. It is the inverse-direction counterpart of the team's iterative encryption datapath. It accepts a 128-bit cyphertext and a 128-bit cipher key and returns the FIPS-197 plaintext after a fixed 31-cycle latency. It first runs the forward key schedule to round key 10, then unwinds the schedule backwards on the fly, one key per round, so no 11-entry key store is needed. It sits beside the encryption core behind the SPI/top-level wrapper and shares its byte ordering.

---
 rtl/aes_inv_cipher.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/aes_inv_cipher.sv
// Iterative AES-128 decryption core. Runs the forward key schedule up to
// round key 10, then walks the schedule backwards one key per round while
// unwinding the cipher state. Byte order is column-major: [127:120] = s(0,0).
//
// state  | meaning
// IDLE   | waiting for start, outputs cleared
// KEYFWD | forward key expansion k0 -> k10, one round key per cycle
// ARK    | initial AddRoundKey with k10
// SUB    | inverse S-box ROM read of InvShiftRows(st); step key back one round
// MIX    | AddRoundKey, then InvMixColumns except on the final round
// DONE   | plaintext valid and held; start restarts directly
module aes_inv_cipher (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [127:0] key,
   input  logic [127:0] cyphertext,
   output logic [127:0] plaintext,
   output logic         done,
   output logic         busy
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] KEYFWD = 3'd1;
   localparam logic [2:0] ARK    = 3'd2;
   localparam logic [2:0] SUB    = 3'd3;
   localparam logic [2:0] MIX    = 3'd4;
   localparam logic [2:0] DONE   = 3'd5;

   logic [2:0]   state;
   logic [127:0] st;
   logic [127:0] kr;
   logic [3:0]   rnd;
   logic [127:0] sb;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] sq;
      logic [7:0] acc;
      sq  = gf_mul(a, a);
      acc = sq;
      for (int i = 0; i < 6; i++) begin
         sq  = gf_mul(sq, sq);
         acc = gf_mul(acc, sq);
      end
      return acc;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
      logic [15:0] t;
      t = {a, a};
      return t[15-n -: 8];
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] x;
      x = gf_inv(a);
      return x ^ rotl8(x, 1) ^ rotl8(x, 2) ^ rotl8(x, 3) ^ rotl8(x, 4) ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] a);
      return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] r);
      case (r)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   // SubWord(RotWord(w)) ^ Rcon, the only nonlinear part of the schedule.
   function automatic logic [31:0] key_core(input logic [31:0] w, input logic [3:0] r);
      return {sbox(w[23:16]) ^ rcon(r), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
   endfunction

   function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [3:0] r);
      logic [31:0] a, b, c, d;
      a = k[127:96] ^ key_core(k[31:0], r);
      b = k[95:64] ^ a;
      c = k[63:32] ^ b;
      d = k[31:0] ^ c;
      return {a, b, c, d};
   endfunction

   function automatic logic [127:0] key_bwd(input logic [127:0] k, input logic [3:0] r);
      logic [31:0] a, b, c, d;
      d = k[31:0] ^ k[63:32];
      c = k[63:32] ^ k[95:64];
      b = k[95:64] ^ k[127:96];
      a = k[127:96] ^ key_core(d, r);
      return {a, b, c, d};
   endfunction

   function automatic logic [127:0] inv_shift(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
      return o;
   endfunction

   function automatic logic [127:0] inv_mix(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a [4];
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) a[r] = s[127-8*(4*c+r) -: 8];
         for (int r = 0; r < 4; r++)
            o[127-8*(4*c+r) -: 8] = gf_mul(a[r], 8'h0e) ^ gf_mul(a[(r+1)%4], 8'h0b)
                                  ^ gf_mul(a[(r+2)%4], 8'h0d) ^ gf_mul(a[(r+3)%4], 8'h09);
      end
      return o;
   endfunction

   // Sixteen synchronous inverse S-box ROMs addressed by InvShiftRows(st);
   // the read issued in SUB is consumed in MIX.
   always_ff @(posedge clk) begin
      for (int j = 0; j < 16; j++)
         sb[127-8*j -: 8] <= inv_sbox(inv_shift(st)[127-8*j -: 8]);
   end

   // Control FSM together with the state, round-key and round-counter datapath.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         st    <= '0;
         kr    <= '0;
         rnd   <= 4'd0;
         done  <= 1'b0;
         busy  <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  st    <= cyphertext;
                  kr    <= key;
                  rnd   <= 4'd1;
                  done  <= 1'b0;
                  busy  <= 1'b1;
                  state <= KEYFWD;
               end
            end
            KEYFWD: begin
               kr  <= key_fwd(kr, rnd);
               rnd <= rnd + 4'd1;
               if (rnd == 4'd10) state <= ARK;
            end
            ARK: begin
               st    <= st ^ kr;
               rnd   <= 4'd10;
               state <= SUB;
            end
            SUB: begin
               kr    <= key_bwd(kr, rnd);
               state <= MIX;
            end
            MIX: begin
               rnd <= rnd - 4'd1;
               if (rnd != 4'd1) begin
                  st    <= inv_mix(sb ^ kr);
                  state <= SUB;
               end else begin
                  st    <= sb ^ kr;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign plaintext = st;

endmodule
